usbdev_line_monitor: RTL
========================

// Module: usbdev_line_monitor
// PURPOSE
//  Receive-side consumer of the synchronized USB pins from the IO mux. Filters the raw
//  D+/D- and VBUS sense, decodes the full-speed line state (SE0/J/K/SE1) and tracks the
//  device link state. Emits one-cycle events for bus reset, suspend, resume, connect and
//  disconnect to the usbdev core and interrupt logic.
// PARAMETERS
//  DebounceCycles  4       consecutive identical raw samples to accept a new line state
//  VbusDebCycles   48      consecutive identical samples to accept a new VBUS level
//  ResetCycles     120     filtered SE0 length that is a bus reset (2.5us @ 48MHz)
//  SuspendCycles   144000  filtered continuous J (idle) length that is suspend (3ms @ 48MHz)
// PORTS
//  clk_i            in   1  USB clock (48 MHz)
//  rst_ni           in   1  async active-low reset
//  usb_rx_dp_i      in   1  synchronized D+
//  usb_rx_dn_i      in   1  synchronized D-
//  usb_pwr_sense_i  in   1  synchronized VBUS sense
//  pullup_en_i      in   1  device D+ pull-up enabled (attached)
//  line_state_o     out  2  filtered line state: 0 SE0, 1 J (dp=1,dn=0), 2 K, 3 SE1
//  vbus_o           out  1  debounced VBUS
//  link_state_o     out  3  link_state_e: DISCONNECTED, POWERED, ACTIVE, SUSPENDED, RESUMING
//  bus_reset_o      out  1  level: SE0 has lasted >= ResetCycles and still present
//  ev_bus_reset_o   out  1  pulse: bus reset detected
//  ev_suspend_o     out  1  pulse: entered SUSPENDED
//  ev_resume_o      out  1  pulse: RESUMING -> ACTIVE
//  ev_connect_o     out  1  pulse: DISCONNECTED -> POWERED
//  ev_disconnect_o  out  1  pulse: any state -> DISCONNECTED
// BEHAVIOUR
//  - Reset: line_state_o=SE0, vbus_o=0, link_state_o=DISCONNECTED, all levels/pulses 0, counters 0.
//  - Line filter: raw {dp,dn} compared to held candidate; counter clears on change; filtered
//    state updates when candidate stable DebounceCycles cycles -> latency DebounceCycles+1 clk.
//    VBUS filtered identically with VbusDebCycles.
//  - se0_cnt: +1 per cycle filtered SE0, clears otherwise, saturates at ResetCycles.
//    ev_bus_reset_o pulses the cycle se0_cnt reaches ResetCycles; exactly once per SE0 episode.
//    bus_reset_o high from that cycle until filtered state leaves SE0.
//  - idle_cnt: +1 per cycle filtered J, clears on any non-J or state change, saturates at SuspendCycles.
//  - Link FSM, priority top-down, evaluated every cycle:
//    1 !vbus_o or !pullup_en_i -> DISCONNECTED (ev_disconnect_o if not already DISCONNECTED)
//    2 bus reset event in POWERED/ACTIVE/SUSPENDED/RESUMING -> ACTIVE
//    3 DISCONNECTED & vbus_o & pullup_en_i -> POWERED, ev_connect_o
//    4 ACTIVE & idle_cnt reaches SuspendCycles -> SUSPENDED, ev_suspend_o
//    5 SUSPENDED & filtered K -> RESUMING
//    6 RESUMING & filtered J entered after SE0 seen (EOP) -> ACTIVE, ev_resume_o;
//      RESUMING & J directly after K (no SE0) -> back to SUSPENDED, no event
//  - POWERED never suspends; only a bus reset makes it ACTIVE.
//  - Simultaneous disconnect and bus reset: disconnect wins, no ev_bus_reset_o.
//  - Events are single-cycle, registered, mutually exclusive per cycle.
//  - SE1 is held as line state but is neither idle nor reset; clears idle_cnt and se0_cnt.
//  - Counter widths $clog2(param+1); no wrap (saturate).
// STRUCTURE
//  - usbdev_pkg: line_state_e (2b) and link_state_e (3b) typedefs, shared with core/regs.
//  - Sub-module usbdev_line_debounce #(Width, Cycles): generic stable-count filter, instanced
//    twice (Width=2 for D+/D-, Width=1 for VBUS). FSM and counters live in this module.
// TESTING
//  - Reset, VBUS=1, pullup=1, J held: vbus_o after 49 clk, ev_connect_o once, link=POWERED.
//  - POWERED, SE0 for 130 clk: ev_bus_reset_o once at 120th filtered SE0 cycle, link=ACTIVE,
//    bus_reset_o high until J returns; SE0 of 100 clk gives no event.
//  - ACTIVE, J idle 144000 clk: ev_suspend_o once, link=SUSPENDED; a K glitch of 3 clk
//    (< DebounceCycles) does not clear idle_cnt or wake.
//  - SUSPENDED, K 20ms then SE0 2 clk-bits then J: ev_resume_o once, link=ACTIVE.
//  - ACTIVE, VBUS drops while SE0 counting at 119: ev_disconnect_o only, link=DISCONNECTED.
//  - Async reset asserted mid-SUSPENDED: all outputs return to reset values immediately.

Source files
------------

// File: rtl/usbdev_pkg.sv
// Shared USB device types: filtered line state and device link state.
// Also holds the D+/D- to line-state decode used by the receive monitor.
package usbdev_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2,
        LS_SE1 = 2'd3
    } line_state_e;

    typedef enum logic [2:0] {
        LINK_DISCONNECTED = 3'd0,
        LINK_POWERED      = 3'd1,
        LINK_ACTIVE       = 3'd2,
        LINK_SUSPENDED    = 3'd3,
        LINK_RESUMING     = 3'd4
    } link_state_e;

    // Full-speed signalling: J is D+ high / D- low, K is the opposite.
    function automatic line_state_e decode_line(input logic [1:0] dp_dn);
        line_state_e ls;
        case (dp_dn)
            2'b00:   ls = LS_SE0;
            2'b10:   ls = LS_J;
            2'b01:   ls = LS_K;
            default: ls = LS_SE1;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usbdev_line_debounce.sv
// Stable-count filter: the output takes a new value only after the input has
// held that value for Cycles consecutive samples beyond the first one.
module usbdev_line_debounce #(
    parameter int Width  = 1,
    parameter int Cycles = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    localparam int CntW = $clog2(Cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles);

    logic [Width-1:0] r_cand;
    logic [Width-1:0] r_q;
    logic [CntW-1:0]  r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else if (i_d != r_cand) begin
            r_cand <= i_d;
            r_cnt  <= '0;
        end else begin
            if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Accept on the sample that completes the stable run.
            if (r_cnt == CntMax - 1'b1) begin
                r_q <= r_cand;
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/usbdev_line_monitor.sv
// USB receive line monitor: filters D+/D-/VBUS, decodes the line state and
// tracks the device link state, emitting one-cycle link events.
module usbdev_line_monitor
    import usbdev_pkg::*;
#(
    parameter int DebounceCycles = 4,
    parameter int VbusDebCycles  = 48,
    parameter int ResetCycles    = 120,
    parameter int SuspendCycles  = 144000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        usb_rx_dp_i,
    input  logic        usb_rx_dn_i,
    input  logic        usb_pwr_sense_i,
    input  logic        pullup_en_i,
    output line_state_e line_state_o,
    output logic        vbus_o,
    output link_state_e link_state_o,
    output logic        bus_reset_o,
    output logic        ev_bus_reset_o,
    output logic        ev_suspend_o,
    output logic        ev_resume_o,
    output logic        ev_connect_o,
    output logic        ev_disconnect_o
);

    localparam int Se0W  = $clog2(ResetCycles + 1);
    localparam int IdleW = $clog2(SuspendCycles + 1);
    localparam logic [Se0W-1:0]  Se0Max  = Se0W'(ResetCycles);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(SuspendCycles);

    logic [1:0]       w_pins;
    logic [0:0]       w_vbus;
    line_state_e      w_line;
    logic             w_rst_hit;
    logic             w_idle_hit;
    link_state_e      r_state;
    link_state_e      w_state_d;
    logic [Se0W-1:0]  r_se0_cnt;
    logic [IdleW-1:0] r_idle_cnt;
    logic             r_se0_seen;
    logic             w_ev_bus_reset, w_ev_suspend, w_ev_resume, w_ev_connect, w_ev_disconnect;
    logic             r_ev_bus_reset, r_ev_suspend, r_ev_resume, r_ev_connect, r_ev_disconnect;

    usbdev_line_debounce #(.Width(2), .Cycles(DebounceCycles)) u_line_deb (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_d     ({usb_rx_dp_i, usb_rx_dn_i}),
        .o_q     (w_pins)
    );

    usbdev_line_debounce #(.Width(1), .Cycles(VbusDebCycles)) u_vbus_deb (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_d     (usb_pwr_sense_i),
        .o_q     (w_vbus)
    );

    assign w_line     = decode_line(w_pins);
    assign w_rst_hit  = (w_line == LS_SE0) && (r_se0_cnt == Se0Max - 1'b1);
    assign w_idle_hit = (w_line == LS_J) && (r_idle_cnt == IdleMax - 1'b1);

    // SE1 is neither idle nor reset, so it clears both counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_se0_cnt  <= '0;
            r_idle_cnt <= '0;
            r_se0_seen <= 1'b0;
        end else begin
            if (w_line != LS_SE0) begin
                r_se0_cnt <= '0;
            end else if (r_se0_cnt != Se0Max) begin
                r_se0_cnt <= r_se0_cnt + 1'b1;
            end
            if (w_line != LS_J) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IdleMax) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            r_se0_seen <= (r_state == LINK_RESUMING) && (r_se0_seen || (w_line == LS_SE0));
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_ev_bus_reset  = 1'b0;
        w_ev_suspend    = 1'b0;
        w_ev_resume     = 1'b0;
        w_ev_connect    = 1'b0;
        w_ev_disconnect = 1'b0;
        if (!w_vbus[0] || !pullup_en_i) begin
            w_state_d       = LINK_DISCONNECTED;
            w_ev_disconnect = (r_state != LINK_DISCONNECTED);
        end else if (w_rst_hit && (r_state != LINK_DISCONNECTED)) begin
            w_state_d      = LINK_ACTIVE;
            w_ev_bus_reset = 1'b1;
        end else begin
            case (r_state)
                LINK_DISCONNECTED: begin
                    w_state_d    = LINK_POWERED;
                    w_ev_connect = 1'b1;
                end
                LINK_ACTIVE: begin
                    if (w_idle_hit) begin
                        w_state_d    = LINK_SUSPENDED;
                        w_ev_suspend = 1'b1;
                    end
                end
                LINK_SUSPENDED: begin
                    if (w_line == LS_K) begin
                        w_state_d = LINK_RESUMING;
                    end
                end
                LINK_RESUMING: begin
                    // Only a proper EOP (SE0 then J) completes the resume.
                    if (w_line == LS_J) begin
                        w_state_d   = r_se0_seen ? LINK_ACTIVE : LINK_SUSPENDED;
                        w_ev_resume = r_se0_seen;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= LINK_DISCONNECTED;
            r_ev_bus_reset  <= 1'b0;
            r_ev_suspend    <= 1'b0;
            r_ev_resume     <= 1'b0;
            r_ev_connect    <= 1'b0;
            r_ev_disconnect <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_ev_bus_reset  <= w_ev_bus_reset;
            r_ev_suspend    <= w_ev_suspend;
            r_ev_resume     <= w_ev_resume;
            r_ev_connect    <= w_ev_connect;
            r_ev_disconnect <= w_ev_disconnect;
        end
    end

    assign line_state_o    = w_line;
    assign vbus_o          = w_vbus[0];
    assign link_state_o    = r_state;
    assign bus_reset_o     = (r_se0_cnt == Se0Max) && (w_line == LS_SE0);
    assign ev_bus_reset_o  = r_ev_bus_reset;
    assign ev_suspend_o    = r_ev_suspend;
    assign ev_resume_o     = r_ev_resume;
    assign ev_connect_o    = r_ev_connect;
    assign ev_disconnect_o = r_ev_disconnect;

endmodule
